// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand/command sequencer: data width,
// opcode encodings, FSM state encoding and the legal-opcode decoder.
package alu_pkg;

    localparam int DW = 9;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_SLL = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_WRITE = 3'd3,
        S_ERR   = 3'd4
    } state_e;

    // Only the four arithmetic/shift opcodes may be sequenced to the ALU.
    function automatic logic op_is_legal(input logic [2:0] op);
        logic legal;
        case (op)
            OP_ADD, OP_SUB, OP_SRL, OP_SLL: legal = 1'b1;
            default:                        legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command, ALU-side and host-port signals of the sequencer bundled together.
// master = command/host/ALU-result driver, slave = the sequencer.
interface alu_op_sequencer_if #(parameter int AW = 3);

    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [2:0]               cmd_op;
    logic [AW-1:0]            cmd_rd;
    logic [AW-1:0]            cmd_rs;
    logic [AW-1:0]            cmd_rt;

    logic [2:0]               alu_instruction;
    logic [alu_pkg::DW-1:0]   alu_a;
    logic [alu_pkg::DW-1:0]   alu_b;
    logic [alu_pkg::DW-1:0]   alu_result;

    logic                     done;
    logic [alu_pkg::DW-1:0]   done_data;
    logic                     err;

    logic                     host_wr_en;
    logic                     host_wr_ready;
    logic [AW-1:0]            host_wr_addr;
    logic [alu_pkg::DW-1:0]   host_wr_data;
    logic [AW-1:0]            host_rd_addr;
    logic [alu_pkg::DW-1:0]   host_rd_data;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_rt, alu_result,
               host_wr_en, host_wr_addr, host_wr_data, host_rd_addr,
        input  cmd_ready, alu_instruction, alu_a, alu_b, done, done_data, err,
               host_wr_ready, host_rd_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_rt, alu_result,
               host_wr_en, host_wr_addr, host_wr_data, host_rd_addr,
        output cmd_ready, alu_instruction, alu_a, alu_b, done, done_data, err,
               host_wr_ready, host_rd_data
    );

endinterface

// File: rtl/alu_regfile.sv
// NREGS x 9-bit register file: one synchronous write port, combinational
// read ports for the two operand sources and the host.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rs_addr,
    output logic [DW-1:0] rs_data,
    input  logic [AW-1:0] rt_addr,
    output logic [DW-1:0] rt_data,
    input  logic [AW-1:0] host_addr,
    output logic [DW-1:0] host_data
);

    logic [DW-1:0] regs_q [NREGS];
    logic [DW-1:0] regs_d [NREGS];

    // Next register-file contents: at most one entry replaced per cycle.
    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[wr_addr] = wr_data;
        end else begin
            regs_d = regs_q;
        end
    end

    // Register-file storage with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= {DW{1'b0}};
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Reads see the pre-edge value, so a same-cycle write is not forwarded.
    assign rs_data   = regs_q[rs_addr];
    assign rt_data   = regs_q[rt_addr];
    assign host_data = regs_q[host_addr];

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one register-to-register command at a time through the external
// sign-magnitude ALU: fetch operands, pulse the opcode for one cycle, capture
// the result and write it back. Illegal opcodes are rejected with an err pulse.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int NREGS = 8
) (
    input  logic              clk,
    input  logic              rst,
    alu_op_sequencer_if.slave bus
);

    localparam int AW = $clog2(NREGS);

    state_e        state_q,       state_d;
    logic [2:0]    op_q,          op_d;
    logic [AW-1:0] rd_q,          rd_d;
    logic [AW-1:0] rs_q,          rs_d;
    logic [AW-1:0] rt_q,          rt_d;
    logic [DW-1:0] alu_a_q,       alu_a_d;
    logic [DW-1:0] alu_b_q,       alu_b_d;
    logic [2:0]    alu_instr_q,   alu_instr_d;
    logic [DW-1:0] result_q,      result_d;
    logic          done_q,        done_d;
    logic [DW-1:0] done_data_q,   done_data_d;
    logic          err_q,         err_d;

    logic          rf_we_s;
    logic [AW-1:0] rf_waddr_s;
    logic [DW-1:0] rf_wdata_s;
    logic [DW-1:0] rs_data_s;
    logic [DW-1:0] rt_data_s;

    alu_regfile #(.NREGS(NREGS), .AW(AW)) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (rf_we_s),
        .wr_addr   (rf_waddr_s),
        .wr_data   (rf_wdata_s),
        .rs_addr   (rs_q),
        .rs_data   (rs_data_s),
        .rt_addr   (rt_q),
        .rt_data   (rt_data_s),
        .host_addr (bus.host_rd_addr),
        .host_data (bus.host_rd_data)
    );

    // Writeback owns the write port in WRITE; the host gets it otherwise.
    always_comb begin
        if (state_q == S_WRITE) begin
            rf_we_s    = 1'b1;
            rf_waddr_s = rd_q;
            rf_wdata_s = result_q;
        end else begin
            rf_we_s    = bus.host_wr_en;
            rf_waddr_s = bus.host_wr_addr;
            rf_wdata_s = bus.host_wr_data;
        end
    end

    // Next-state and registered-output logic. The opcode register is loaded
    // on entry to EXEC only, so the ALU always sees NOP -> op -> NOP edges.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rd_d        = rd_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_instr_d = OP_NOP;
        result_d    = result_q;
        done_d      = 1'b0;
        done_data_d = done_data_q;
        err_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    op_d = bus.cmd_op;
                    rd_d = bus.cmd_rd;
                    rs_d = bus.cmd_rs;
                    rt_d = bus.cmd_rt;
                    if (op_is_legal(bus.cmd_op)) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                alu_a_d     = rs_data_s;
                alu_b_d     = rt_data_s;
                alu_instr_d = op_q;
                state_d     = S_EXEC;
            end
            S_EXEC: begin
                result_d    = bus.alu_result;
                done_data_d = bus.alu_result;
                done_d      = 1'b1;
                state_d     = S_WRITE;
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, latched command, operand and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= OP_NOP;
            rd_q        <= {AW{1'b0}};
            rs_q        <= {AW{1'b0}};
            rt_q        <= {AW{1'b0}};
            alu_a_q     <= {DW{1'b0}};
            alu_b_q     <= {DW{1'b0}};
            alu_instr_q <= OP_NOP;
            result_q    <= {DW{1'b0}};
            done_q      <= 1'b0;
            done_data_q <= {DW{1'b0}};
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_instr_q <= alu_instr_d;
            result_q    <= result_d;
            done_q      <= done_d;
            done_data_q <= done_data_d;
            err_q       <= err_d;
        end
    end

    assign bus.cmd_ready       = (state_q == S_IDLE);
    assign bus.host_wr_ready   = (state_q != S_WRITE);
    assign bus.alu_instruction = alu_instr_q;
    assign bus.alu_a           = alu_a_q;
    assign bus.alu_b           = alu_b_q;
    assign bus.done            = done_q;
    assign bus.done_data       = done_data_q;
    assign bus.err             = err_q;

endmodule
